// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP crop engine.
//   crop_state_t  : control FSM states
//   BMP_HDR_BYTES : BMP file + info header size, skipped in source and destination
//   pad4()        : round a byte count up to the next multiple of four (BMP row size)
package bmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } crop_state_t;

  localparam int BMP_HDR_BYTES = 54;

  function automatic logic [23:0] pad4(input logic [23:0] n);
    return (n + 24'd3) & ~24'd3;
  endfunction

endpackage

// File: rtl/bmp_delay_line.sv
// Token delay line that tracks the source read latency.
// Each issued token carries {valid, is_pad}; it leaves DEPTH cycles later,
// aligned with the read data returned for that token.
//   clk, rst_n : clock, synchronous active-low clear of all stages
//   i_vld/i_pad: token entering this cycle
//   o_vld/o_pad: token leaving this cycle
//   o_any      : at least one stage holds a valid token
module bmp_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_pad,
  output logic o_vld,
  output logic o_pad,
  output logic o_any
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_pad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_pad <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_pad[0] <= i_pad;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pad[i] <= r_pad[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_pad = r_pad[DEPTH-1];
  assign o_any = |r_vld;

endmodule

// File: rtl/bmp_crop_engine.sv
// Streaming crop of a rectangular window out of a bottom-up BMP pixel array.
// One token per cycle: pixel tokens read a source byte, pad tokens emit a
// zero so every destination row is a multiple of four bytes.
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : pulse, latches all configuration inputs
//   src_base, dst_base    : file base addresses (header is skipped)
//   src_width, src_height : source dimensions in pixels
//   x_min..y_max, flip_h  : inclusive top-down window, horizontal mirror
//   busy, done, error     : job status (done/error are sticky until next start)
//   rd_en, rd_addr, rd_data : source read port, data RD_LAT cycles after rd_en
//   wr_en, wr_addr, wr_data : destination write port, contiguous addresses
//   dst_row_bytes, dst_img_bytes : padded destination sizes, valid in DONE
module bmp_crop_engine
  import bmp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DIM_W     = 11,
  parameter int BPP       = 3,
  parameter int HDR_BYTES = BMP_HDR_BYTES,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  src_width,
  input  logic [DIM_W-1:0]  src_height,
  input  logic [DIM_W-1:0]  x_min,
  input  logic [DIM_W-1:0]  x_max,
  input  logic [DIM_W-1:0]  y_min,
  input  logic [DIM_W-1:0]  y_max,
  input  logic              flip_h,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [23:0]       dst_row_bytes,
  output logic [ADDR_W-1:0] dst_img_bytes
);

  crop_state_t r_state;

  // latched configuration
  logic [ADDR_W-1:0] r_src_base, r_dst_base;
  logic [DIM_W-1:0]  r_sw, r_sh, r_xmin, r_xmax, r_ymin, r_ymax;
  logic              r_flip;

  // job geometry, fixed once CHECK passes
  logic [23:0]       r_src_rb, r_dst_rb;
  logic [1:0]        r_pad;
  logic [ADDR_W-1:0] r_xoff0, r_wr_base;

  // traversal state
  logic [ADDR_W-1:0] r_rb, r_addr;
  logic [DIM_W-1:0]  r_x, r_y;
  logic [1:0]        r_b, r_padcnt;
  logic              r_in_pad;

  // issue register and write stage
  logic              r_iss_vld, r_iss_pad;
  logic [ADDR_W-1:0] r_wcnt;

  logic              r_busy, r_done, r_error, r_rd_en, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr, r_img_bytes;
  logic [7:0]        r_wr_data;
  logic [23:0]       r_row_bytes;

  logic              w_cfg_bad, w_last_byte, w_row_end;
  logic              w_dl_vld, w_dl_pad, w_dl_any;
  logic [DIM_W-1:0]  w_win_w, w_x_first, w_x_last;
  logic [23:0]       w_win_bytes, w_src_rb, w_dst_rb;
  logic [ADDR_W-1:0] w_xoff0, w_rb0, w_rb_next;

  assign w_cfg_bad = (r_xmin > r_xmax) || (r_ymin > r_ymax) ||
                     (r_xmax >= r_sw) || (r_ymax >= r_sh) ||
                     (r_sw == '0) || (r_sh == '0);

  assign w_win_w     = r_xmax - r_xmin + DIM_W'(1);
  assign w_win_bytes = 24'(w_win_w) * 24'(BPP);
  assign w_src_rb    = pad4(24'(r_sw) * 24'(BPP));
  assign w_dst_rb    = pad4(w_win_bytes);
  assign w_x_first   = r_flip ? r_xmax : r_xmin;
  assign w_x_last    = r_flip ? r_xmin : r_xmax;
  assign w_xoff0     = ADDR_W'(w_x_first) * ADDR_W'(BPP);

  // Rows are stored bottom-up: top-down row y_max sits (height-1-y_max) rows
  // above the start of the pixel array.
  assign w_rb0 = r_src_base + ADDR_W'(HDR_BYTES) +
                 ADDR_W'(r_sh - r_ymax - DIM_W'(1)) * ADDR_W'(w_src_rb);
  assign w_rb_next = r_rb + ADDR_W'(r_src_rb);

  assign w_last_byte = (r_b == 2'(BPP - 1));
  assign w_row_end   = r_in_pad ? (r_padcnt == r_pad - 2'd1)
                                : (w_last_byte && (r_x == w_x_last) && (r_pad == 2'd0));

  bmp_delay_line #(.DEPTH(RD_LAT)) u_dl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (r_iss_vld),
    .i_pad (r_iss_pad),
    .o_vld (w_dl_vld),
    .o_pad (w_dl_pad),
    .o_any (w_dl_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_row_bytes <= '0;
      r_img_bytes <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_pad   <= 1'b0;
      r_wcnt      <= '0;
    end else begin
      r_rd_en   <= 1'b0;
      r_iss_vld <= 1'b0;
      r_iss_pad <= 1'b0;

      // write stage: token leaving the delay line meets its read data
      r_wr_en <= w_dl_vld;
      if (w_dl_vld) begin
        r_wr_data <= w_dl_pad ? 8'h00 : rd_data;
        r_wr_addr <= r_wr_base + r_wcnt;
        r_wcnt    <= r_wcnt + ADDR_W'(1);
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_src_base <= src_base;
            r_dst_base <= dst_base;
            r_sw       <= src_width;
            r_sh       <= src_height;
            r_xmin     <= x_min;
            r_xmax     <= x_max;
            r_ymin     <= y_min;
            r_ymax     <= y_max;
            r_flip     <= flip_h;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (w_cfg_bad) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_ERR;
          end else begin
            r_src_rb  <= w_src_rb;
            r_dst_rb  <= w_dst_rb;
            r_pad     <= 2'(w_dst_rb - w_win_bytes);
            r_xoff0   <= w_xoff0;
            r_rb      <= w_rb0;
            r_addr    <= w_rb0 + w_xoff0;
            r_x       <= w_x_first;
            r_y       <= r_ymax;
            r_b       <= 2'd0;
            r_padcnt  <= 2'd0;
            r_in_pad  <= 1'b0;
            r_wcnt    <= '0;
            r_wr_base <= r_dst_base + ADDR_W'(HDR_BYTES);
            r_state   <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_iss_vld <= 1'b1;
          r_iss_pad <= r_in_pad;
          r_rd_en   <= !r_in_pad;
          if (!r_in_pad) r_rd_addr <= r_addr + ADDR_W'(r_b);

          if (w_row_end) begin
            r_in_pad <= 1'b0;
            r_padcnt <= 2'd0;
            r_b      <= 2'd0;
            r_x      <= w_x_first;
            r_rb     <= w_rb_next;
            r_addr   <= w_rb_next + r_xoff0;
            if (r_y == r_ymin) r_state <= ST_DRAIN;
            else               r_y     <= r_y - DIM_W'(1);
          end else if (r_in_pad) begin
            r_padcnt <= r_padcnt + 2'd1;
          end else if (w_last_byte) begin
            r_b <= 2'd0;
            if (r_x == w_x_last) begin
              r_in_pad <= 1'b1;
            end else begin
              r_x    <= r_flip ? r_x - DIM_W'(1) : r_x + DIM_W'(1);
              r_addr <= r_flip ? r_addr - ADDR_W'(BPP) : r_addr + ADDR_W'(BPP);
            end
          end else begin
            r_b <= r_b + 2'd1;
          end
        end

        ST_DRAIN: begin
          // empty pipeline means the last write is on the port this cycle
          if (!r_iss_vld && !w_dl_any) begin
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_row_bytes <= r_dst_rb;
            r_img_bytes <= r_wcnt;
            r_state     <= ST_DONE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign dst_row_bytes = r_row_bytes;
  assign dst_img_bytes = r_img_bytes;

endmodule

// File: tb/tb_bmp_crop_engine.sv
module tb_bmp_crop_engine;

  localparam int NI = 5;  // 0:BPP3/LAT2 1:BPP3/LAT1 2:BPP3/LAT4 3:BPP1/LAT2 4:BPP4/LAT2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] src_base, dst_base;
  logic [10:0] src_width, src_height, x_min, x_max, y_min, y_max;
  logic        flip_h;

  logic        start [NI];
  logic        busy [NI], done [NI], error [NI], rd_en [NI], wr_en [NI];
  logic [31:0] rd_addr [NI], wr_addr [NI], dst_img_bytes [NI];
  logic [7:0]  rd_data [NI], wr_data [NI];
  logic [23:0] dst_row_bytes [NI];

  function automatic logic [7:0] src_byte(input logic [31:0] a);
    return 8'((a * 32'd37) + (a >> 8) + 32'd11);
  endfunction

  function automatic int inst_bpp(input int i);
    return (i == 3) ? 1 : ((i == 4) ? 4 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GB = (g == 3) ? 1 : ((g == 4) ? 4 : 3);
    localparam int GL = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    logic [7:0] rq [GL];

    bmp_crop_engine #(
      .ADDR_W(32), .DIM_W(11), .BPP(GB), .HDR_BYTES(54), .RD_LAT(GL)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]),
      .src_base(src_base), .dst_base(dst_base),
      .src_width(src_width), .src_height(src_height),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .flip_h(flip_h),
      .busy(busy[g]), .done(done[g]), .error(error[g]),
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .dst_row_bytes(dst_row_bytes[g]), .dst_img_bytes(dst_img_bytes[g])
    );

    // fixed-latency source memory; idle cycles return a marker byte
    always @(posedge clk) begin
      rq[0] <= rd_en[g] ? src_byte(rd_addr[g]) : 8'hEE;
      for (int i = 1; i < GL; i++) rq[i] <= rq[i-1];
    end
    assign rd_data[g] = rq[GL-1];
  end

  typedef struct {
    int inst; int sb; int db; int sw; int sh;
    int x0; int x1; int y0; int y1; int flip;
    int err; int rb; int img; int frd;
  } vec_t;

  vec_t tbl [14];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_vec = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0d expected %0d", cur_vec, nm, act, exp);
    end
  endtask

  task automatic start_job(input vec_t v);
    src_base   = 32'(v.sb);
    dst_base   = 32'(v.db);
    src_width  = 11'(v.sw);
    src_height = 11'(v.sh);
    x_min      = 11'(v.x0);
    x_max      = 11'(v.x1);
    y_min      = 11'(v.y0);
    y_max      = 11'(v.y1);
    flip_h     = (v.flip != 0);
    start[v.inst] = 1'b1;
    @(posedge clk); #1;
    start[v.inst] = 1'b0;
    check("start_busy", int'(busy[v.inst]), 1);
    check("start_flags_clear", int'(done[v.inst]) + int'(error[v.inst]), 0);
  endtask

  task automatic run_entry(input vec_t v);
    int i, c, nw, nrd, first_rd, fin_cyc, bpp, srb, wpx, hpx, drb, n;
    int y, xi, x, b, ea;
    bit fin;
    logic [31:0] ga [256];
    logic [7:0]  gd [256];
    int          gc [256];
    logic [7:0]  eb;

    i = v.inst;
    start_job(v);
    c = 0; nw = 0; nrd = 0; first_rd = -1; fin = 1'b0; fin_cyc = 0;
    while (!fin && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (rd_en[i]) begin
        if (first_rd < 0) first_rd = int'(rd_addr[i]);
        nrd++;
      end
      if (wr_en[i]) begin
        if (nw < 256) begin
          ga[nw] = wr_addr[i];
          gd[nw] = wr_data[i];
          gc[nw] = c;
        end
        nw++;
      end
      if (done[i] || error[i]) begin
        fin = 1'b1;
        fin_cyc = c;
      end
    end
    check("job_finished", int'(fin), 1);

    if (v.err != 0) begin
      check("error_flag", int'(error[i]), 1);
      check("error_cycle", fin_cyc, 1);
      check("error_done_low", int'(done[i]), 0);
      check("error_no_reads", nrd, 0);
      check("error_no_writes", nw, 0);
      check("error_busy_low", int'(busy[i]), 0);
    end else begin
      bpp = inst_bpp(i);
      srb = ((v.sw * bpp + 3) / 4) * 4;
      wpx = v.x1 - v.x0 + 1;
      hpx = v.y1 - v.y0 + 1;
      drb = ((wpx * bpp + 3) / 4) * 4;
      check("done_flag", int'(done[i]), 1);
      check("done_error_low", int'(error[i]), 0);
      check("done_busy_low", int'(busy[i]), 0);
      check("first_rd_addr", first_rd, v.frd);
      check("read_count", nrd, wpx * hpx * bpp);
      check("write_count", nw, v.img);
      check("dst_row_bytes", int'(dst_row_bytes[i]), v.rb);
      check("dst_img_bytes", int'(dst_img_bytes[i]), v.img);
      if (nw > 0 && nw <= 256) begin
        check("last_write_cycle", gc[nw-1], fin_cyc - 1);
        check("back_to_back", gc[nw-1] - gc[0], nw - 1);
      end
      n = 0;
      for (int r = 0; r < hpx; r++) begin
        y = v.y1 - r;
        for (int p = 0; p < drb; p++) begin
          if (p < wpx * bpp) begin
            xi = p / bpp;
            b  = p % bpp;
            x  = (v.flip != 0) ? v.x1 - xi : v.x0 + xi;
            ea = v.sb + 54 + (v.sh - 1 - y) * srb + x * bpp + b;
            eb = src_byte(32'(ea));
          end else begin
            eb = 8'h00;
          end
          if (n < 256) begin
            check("wr_addr", int'(ga[n]), v.db + 54 + n);
            check("wr_data", int'(gd[n]), int'(eb));
          end
          n++;
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int act;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    src_base = '0; dst_base = '0; src_width = '0; src_height = '0;
    x_min = '0; x_max = '0; y_min = '0; y_max = '0; flip_h = 1'b0;

    //        inst sb    db    sw sh x0 x1 y0 y1 fl err rb  img frd
    tbl[0]  = '{0, 0,    0,    4, 4, 1, 2, 1, 2, 0, 0,  8,  16, 69};
    tbl[1]  = '{0, 0,    0,    4, 4, 1, 2, 1, 2, 1, 0,  8,  16, 72};
    tbl[2]  = '{1, 0,    0,    3, 1, 0, 2, 0, 0, 0, 0,  12, 12, 54};
    tbl[3]  = '{2, 0,    0,    3, 1, 0, 2, 0, 0, 0, 0,  12, 12, 54};
    tbl[4]  = '{3, 0,    0,    5, 3, 0, 4, 0, 2, 0, 0,  8,  24, 54};
    tbl[5]  = '{4, 0,    0,    5, 3, 0, 4, 0, 2, 0, 0,  20, 60, 54};
    tbl[6]  = '{0, 0,    0,    4, 4, 1, 4, 1, 2, 0, 1,  0,  0,  -1};
    tbl[7]  = '{0, 0,    0,    4, 4, 3, 3, 0, 0, 0, 0,  4,  4,  99};
    tbl[8]  = '{0, 0,    0,    5, 2, 2, 4, 0, 1, 0, 0,  12, 24, 60};
    tbl[9]  = '{0, 0,    0,    5, 2, 2, 4, 0, 1, 1, 0,  12, 24, 66};
    tbl[10] = '{0, 1000, 2000, 4, 4, 0, 3, 0, 3, 0, 0,  12, 48, 1054};
    tbl[11] = '{0, 0,    0,    4, 4, 1, 2, 2, 1, 0, 1,  0,  0,  -1};
    tbl[12] = '{0, 0,    0,    4, 4, 0, 1, 0, 4, 0, 1,  0,  0,  -1};
    tbl[13] = '{3, 0,    0,    0, 3, 0, 0, 0, 0, 0, 1,  0,  0,  -1};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      cur_vec = 200 + i;
      check("reset_ctrl", int'(busy[i]) + int'(done[i]) + int'(error[i]) +
                          int'(rd_en[i]) + int'(wr_en[i]), 0);
      check("reset_addr", int'(rd_addr[i] | wr_addr[i]), 0);
      check("reset_data", int'(wr_data[i]), 0);
      check("reset_sizes", int'(dst_row_bytes[i]) + int'(dst_img_bytes[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++) begin
      cur_vec = k;
      run_entry(tbl[k]);
    end

    // reset asserted in the middle of RUN, then a clean rerun
    cur_vec = 100;
    start_job(tbl[0]);
    repeat (6) @(posedge clk);
    #1;
    check("midrun_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_busy", int'(busy[0]), 0);
    check("reset_wr_en", int'(wr_en[0]), 0);
    check("reset_rd_en", int'(rd_en[0]), 0);
    check("reset_done", int'(done[0]), 0);
    rst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      act += int'(wr_en[0]) + int'(rd_en[0]) + int'(busy[0]);
    end
    check("idle_quiet", act, 0);
    cur_vec = 101;
    run_entry(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
